// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps zeros through the array after reset or a clr request.
//   state | meaning
//   CLEAR | writing 0 to mem[cnt], host accesses ignored
//   RUN   | array accepting reads and writes
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  ram_state_t        state, next_state;
  logic [ADDR_W-1:0] cnt, next_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      ready <= (next_state == RUN);
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      CLEAR: begin
        if (clr) begin
          next_cnt = '0;
        end else begin
          next_cnt = cnt + ADDR_W'(1);
          if (cnt == {ADDR_W{1'b1}}) next_state = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      default: next_state = CLEAR;
    endcase
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port synchronous RAM with a hardware clear sweep
// and a 1- or 2-stage read pipeline qualified by rd_valid.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("ram_dp_param: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc, rd_acc, bypass;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  ram_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // A clr request swallows the host access presented on the same edge.
  assign wr_acc  = ready & wr_en & ~clr;
  assign rd_acc  = ready & rd_en & ~clr;
  assign bypass  = (RDW_MODE == RDW_WRITE_FIRST) && wr_acc && (wr_addr == rd_addr);
  assign rd_data = bypass ? din : mem[rd_addr];

  // Array is deliberately not reset; the clear sweep owns its initial contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= din;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              stg_valid;
    logic [DATA_W-1:0] stg_data;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stg_valid <= 1'b0;
        stg_data  <= '0;
      end else begin
        stg_valid <= rd_acc;
        if (rd_acc) stg_data <= rd_data;
      end
    end

    assign out_valid = stg_valid;
    assign out_data  = stg_data;
  end else begin : g_lat1
    assign out_valid = rd_acc;
    assign out_data  = rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= out_valid;
      if (out_valid) dout <= out_data;
    end
  end

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench: default, latency-2/write-first, and 32x64 instances of ram_dp_param.
module tb_ram_dp_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, wr_en, rd_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] din;
  logic [7:0] dout_a, dout_b;
  logic       rv_a, rv_b, rdy_a, rdy_b;

  logic        clr_c, wr_en_c, rd_en_c;
  logic [5:0]  wr_addr_c, rd_addr_c;
  logic [31:0] din_c, dout_c;
  logic        rv_c, rdy_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_dp_param u_a (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_a), .rd_valid(rv_a), .ready(rdy_a)
  );

  ram_dp_param #(.RD_LAT(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_b), .rd_valid(rv_b), .ready(rdy_b)
  );

  ram_dp_param #(.DATA_W(32), .ADDR_W(6)) u_c (
    .clk(clk), .rst(rst), .clr(clr_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .din(din_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .dout(dout_c), .rd_valid(rv_c), .ready(rdy_c)
  );

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] din;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] exp_a;  // dout of the latency-1 read-first instance after this edge
    logic [7:0] exp_b;  // data the latency-2 write-first instance returns one edge later
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until ready on instance A (0 if it never rises), plus rd_valid pulses seen meanwhile.
  task automatic wait_ready(output int n, output int nv_a, output int nv_b);
    n = 0; nv_a = 0; nv_b = 0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (rv_a) nv_a++;
      if (rv_b) nv_b++;
      if (rdy_a) begin
        n = e;
        break;
      end
    end
  endtask

  initial begin
    int n, nv_a, nv_b, na, nc, ncv;

    vecs[0] = '{1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h5A, 8'h5A};
    vecs[2] = '{1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 8'h5A, 8'h00};
    vecs[3] = '{1'b1, 4'd7, 8'h22, 1'b1, 4'd7, 8'h11, 8'h22};
    vecs[4] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h22, 8'h22};
    vecs[5] = '{1'b1, 4'd0, 8'hA5, 1'b1, 4'd3, 8'h5A, 8'h5A};
    vecs[6] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'hA5, 8'hA5};
    vecs[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'hA5, 8'h00};
    vecs[8] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'hA5, 8'h00};

    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; din = '0;
    clr_c = 1'b0; wr_en_c = 1'b0; rd_en_c = 1'b0;
    wr_addr_c = '0; rd_addr_c = '0; din_c = '0;

    #3;
    check("reset_dout_a", dout_a, 0);
    check("reset_valid_a", rv_a, 0);
    check("reset_ready_a", rdy_a, 0);
    check("reset_valid_b", rv_b, 0);
    check("reset_ready_c", rdy_c, 0);

    @(negedge clk);
    rst = 1'b1;
    na = 0; nc = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (rdy_a && na == 0) na = e;
      if (rdy_c && nc == 0) nc = e;
      if (na != 0 && nc != 0) break;
    end
    check("ready_edges_a", na, 16);
    check("ready_edges_c", nc, 64);

    // Wide instance: fill then stream back-to-back reads.
    for (int i = 0; i < 64; i++) begin
      wr_en_c = 1'b1; wr_addr_c = 6'(i); din_c = 32'(i) * 32'h01010101;
      tick();
    end
    wr_en_c = 1'b0;
    rd_en_c = 1'b1;
    ncv = 0;
    for (int i = 0; i < 64; i++) begin
      rd_addr_c = 6'(i);
      tick();
      if (rv_c) ncv++;
      check("stream_data_c", dout_c, 32'(i) * 32'h01010101);
    end
    rd_en_c = 1'b0;
    check("stream_valid_cycles_c", ncv, 64);
    tick();
    check("stream_valid_drop_c", rv_c, 0);

    // Post-reset contents are zero.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check("init_valid_a", rv_a, 1);
      check("init_data_a", dout_a, 0);
      if (i > 0) check("init_data_b", dout_b, 0);
    end
    rd_en = 1'b0;
    tick();
    check("init_valid_drop_a", rv_a, 0);
    check("init_tail_valid_b", rv_b, 1);

    // Table: basic write/read, collision, independence, hold.
    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; din = vecs[i].din;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      tick();
      check($sformatf("vec%0d_valid_a", i), rv_a, vecs[i].rd_en);
      check($sformatf("vec%0d_dout_a", i), dout_a, vecs[i].exp_a);
      if (i > 0) begin
        check($sformatf("vec%0d_valid_b", i), rv_b, vecs[i-1].rd_en);
        if (vecs[i-1].rd_en) check($sformatf("vec%0d_dout_b", i), dout_b, vecs[i-1].exp_b);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // clr in RUN after filling with 0xFF.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); din = 8'hFF;
      tick();
    end
    clr = 1'b1; wr_addr = 4'd1; din = 8'h77; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    clr = 1'b0;
    check("clr_ready_drop", rdy_a, 0);
    check("clr_edge_read_ignored", rv_a, 0);
    wr_en = 1'b1; wr_addr = 4'd2; din = 8'h77; rd_en = 1'b1; rd_addr = 4'd2;
    wait_ready(n, nv_a, nv_b);
    wr_en = 1'b0; rd_en = 1'b0;
    check("clr_ready_edges", n, 16);
    check("clr_no_valid_a", nv_a, 0);
    check("clr_no_valid_b", nv_b, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check($sformatf("clr_zero_a%0d", i), dout_a, 0);
    end
    rd_en = 1'b0;

    // Reset with a latency-2 read in flight.
    wr_en = 1'b1; wr_addr = 4'd4; din = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd4;
    tick();
    rd_en = 1'b0;
    check("preread_dout_a", dout_a, 8'h3C);
    #2 rst = 1'b0;
    #1;
    check("rst_read_dout_a", dout_a, 0);
    check("rst_read_valid_a", rv_a, 0);
    check("rst_read_ready_a", rdy_a, 0);
    check("rst_read_valid_b", rv_b, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n, nv_a, nv_b);
    check("rst_read_ready_edges", n, 16);
    check("rst_read_flushed_b", nv_b, 0);

    // Reset in the middle of a clr sweep (cnt = 5).
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midclr_ready_low", rdy_a, 0);
    #2 rst = 1'b0;
    #1;
    check("midclr_rst_ready", rdy_a, 0);
    check("midclr_rst_dout_a", dout_a, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n, nv_a, nv_b);
    check("midclr_ready_edges", n, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
